// File: rtl/alu_host_driver.sv
// Host-side sequencer for the ALU operand/result bus. Takes one request at a
// time, issues BEGIN and the operand words in ALU order, then waits for END
// and returns the two captured result words. A timeout or an END that arrives
// during the start/load phase ends the operation with an error response.
module alu_host_driver #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [7:0] req_x,
   input  logic [7:0] req_y,
   input  logic [7:0] req_xh,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_hi,
   output logic [7:0] rsp_lo,
   output logic       rsp_err,
   output logic       alu_begin,
   output logic [1:0] alu_op_code,
   output logic [7:0] alu_inbus,
   input  logic [7:0] alu_outbus,
   input  logic       alu_end,
   output logic       busy
);

   typedef enum logic [2:0] {
      StIdle, StStart, StLd0, StLd1, StLd2, StWaitEnd, StResp
   } state_e;

   localparam logic [1:0]       OpDiv   = 2'b11;
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [1:0]       op_q;
   logic [7:0]       x_q, y_q, xh_q;
   logic [7:0]       hist_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       rsp_hi_q, rsp_hi_d;
   logic [7:0]       rsp_lo_q, rsp_lo_d;
   logic             rsp_err_q, rsp_err_d;
   logic             is_div;
   logic             accept;
   logic             in_load;

   assign is_div  = (op_q == OpDiv);
   assign accept  = req_valid && (state_q == StIdle);
   assign in_load = (state_q == StStart) || (state_q == StLd0) ||
                    (state_q == StLd1) || (state_q == StLd2);

   // State, timeout counter and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rsp_hi_q  <= 8'h00;
         rsp_lo_q  <= 8'h00;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rsp_hi_q  <= rsp_hi_d;
         rsp_lo_q  <= rsp_lo_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // Capture the request operands on the accepting handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q <= 2'b00;
         x_q  <= 8'h00;
         y_q  <= 8'h00;
         xh_q <= 8'h00;
      end else if (accept) begin
         op_q <= req_op;
         x_q  <= req_x;
         y_q  <= req_y;
         xh_q <= req_xh;
      end
   end

   // One-cycle history of outbus: the A word precedes the END cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= 8'h00;
      end else begin
         hist_q <= alu_outbus;
      end
   end

   // Next-state, timeout counting and response capture
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      rsp_hi_d  = rsp_hi_q;
      rsp_lo_d  = rsp_lo_q;
      rsp_err_d = rsp_err_q;
      case (state_q)
         StIdle:  if (req_valid) state_d = StStart;
         StStart: state_d = StLd0;
         StLd0:   state_d = StLd1;
         StLd1:   state_d = is_div ? StLd2 : StWaitEnd;
         StLd2:   state_d = StWaitEnd;
         StWaitEnd: begin
            cnt_d = cnt_q + 1'b1;
            // END has priority over a timeout in the same cycle
            if (alu_end) begin
               rsp_hi_d  = hist_q;
               rsp_lo_d  = alu_outbus;
               rsp_err_d = 1'b0;
               state_d   = StResp;
            end else if (cnt_q == CntLast) begin
               rsp_hi_d  = 8'h00;
               rsp_lo_d  = 8'h00;
               rsp_err_d = 1'b1;
               state_d   = StResp;
            end
         end
         StResp:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // END before the operands are all loaded aborts the operation
      if (alu_end && in_load) begin
         rsp_hi_d  = 8'h00;
         rsp_lo_d  = 8'h00;
         rsp_err_d = 1'b1;
         state_d   = StResp;
      end
   end

   // ALU-side outputs decoded from the current state
   always_comb begin
      alu_begin   = (state_q == StStart);
      alu_op_code = 2'b00;
      alu_inbus   = 8'h00;
      case (state_q)
         StStart, StWaitEnd: alu_op_code = op_q;
         StLd0: begin
            alu_op_code = op_q;
            alu_inbus   = is_div ? xh_q : x_q;
         end
         StLd1: begin
            alu_op_code = op_q;
            alu_inbus   = is_div ? x_q : y_q;
         end
         StLd2: begin
            alu_op_code = op_q;
            alu_inbus   = y_q;
         end
         default: ;
      endcase
   end

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign busy      = (state_q != StIdle);
   assign rsp_hi    = rsp_hi_q;
   assign rsp_lo    = rsp_lo_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_host_driver.sv
// Bench for alu_host_driver: a behavioural ALU answers the driver's bus
// traffic, expected responses are queued at request time and a separate
// monitor pops and compares them on every response handshake.
module tb_alu_host_driver;

   localparam int ModeNormal = 0;
   localparam int ModeSilent = 1;
   localparam int ModeEarly  = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid, req_ready;
   logic [1:0] req_op;
   logic [7:0] req_x, req_y, req_xh;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_hi, rsp_lo;
   logic       rsp_err;
   logic       alu_begin;
   logic [1:0] alu_op_code;
   logic [7:0] alu_inbus, alu_outbus;
   logic       alu_end;
   logic       busy;

   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
      logic       err;
      logic       chk_data;
   } rsp_t;

   rsp_t exp_q[$];

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int acc_cyc   = -100;
   int rsp_seen  = 0;
   int alu_mode  = ModeNormal;
   int alu_delay = 1;
   int late_req  = 0;

   alu_host_driver #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_xh     (req_xh),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_hi     (rsp_hi),
      .rsp_lo     (rsp_lo),
      .rsp_err    (rsp_err),
      .alu_begin  (alu_begin),
      .alu_op_code(alu_op_code),
      .alu_inbus  (alu_inbus),
      .alu_outbus (alu_outbus),
      .alu_end    (alu_end),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ALU arithmetic: {A, Q}. Divide returns {remainder, quotient}.
   function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [7:0] x,
                                           input logic [7:0] y, input logic [7:0] xh);
      logic [15:0] dvd;
      dvd = {xh, x};
      case (op)
         2'b00:   return 16'(x) + 16'(y);
         2'b01:   return 16'(x) - 16'(y);
         2'b10:   return 16'(x) * 16'(y);
         default: begin
            if (y == 8'h00) return 16'hffff;
            return {8'(dvd % 16'(y)), 8'(dvd / 16'(y))};
         end
      endcase
   endfunction

   // Behavioural ALU: collects operand words after BEGIN, answers with A then Q+END
   initial begin : alu_model
      logic [1:0]  op;
      logic [7:0]  w [3];
      logic [15:0] r;
      int          nw;
      int          late_done;
      bit          aborted;
      late_done  = 0;
      alu_end    = 1'b0;
      alu_outbus = 8'h00;
      forever begin
         @(negedge clk);
         alu_end    = 1'b0;
         alu_outbus = 8'($urandom);
         if (late_req != late_done) begin
            late_done++;
            alu_end = 1'b1;
         end else if (alu_begin && !reset) begin
            chk("begin_cycle", 32'(cyc), 32'(acc_cyc + 1));
            op = alu_op_code;
            if (alu_mode != ModeSilent) begin
               nw      = (op == 2'b11) ? 3 : 2;
               aborted = 0;
               for (int i = 0; i < nw; i++) begin
                  @(negedge clk);
                  alu_outbus = 8'($urandom);
                  w[i] = alu_inbus;
                  chk("begin_single", 32'(alu_begin), 32'(0));
                  chk("opcode_load", 32'(alu_op_code), 32'(op));
                  if (alu_mode == ModeEarly && i == 1) begin
                     alu_end = 1'b1;
                     aborted = 1;
                     break;
                  end
               end
               if (!aborted) begin
                  @(negedge clk);
                  alu_outbus = 8'($urandom);
                  chk("inbus_idle", 32'(alu_inbus), 32'(0));
                  chk("opcode_wait", 32'(alu_op_code), 32'(op));
                  repeat (alu_delay) begin
                     @(negedge clk);
                     alu_outbus = 8'($urandom);
                     chk("opcode_wait", 32'(alu_op_code), 32'(op));
                  end
                  r = (op == 2'b11) ? alu_ref(op, w[1], w[2], w[0])
                                    : alu_ref(op, w[0], w[1], 8'h00);
                  alu_outbus = r[15:8];
                  @(negedge clk);
                  chk("rsp_before_end", 32'(rsp_valid), 32'(0));
                  alu_outbus = r[7:0];
                  alu_end    = 1'b1;
                  @(negedge clk);
                  alu_end    = 1'b0;
                  alu_outbus = 8'($urandom);
                  chk("rsp_latency", 32'(rsp_valid), 32'(1));
               end
            end
         end
      end
   end

   // Response monitor: hold stability while stalled, scoreboard compare on handshake
   initial begin : monitor
      rsp_t       e;
      logic       held;
      logic [7:0] h_hi, h_lo;
      logic       h_err;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (reset || !rsp_valid) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("hold_hi", 32'(rsp_hi), 32'(h_hi));
               chk("hold_lo", 32'(rsp_lo), 32'(h_lo));
               chk("hold_err", 32'(rsp_err), 32'(h_err));
            end
            if (rsp_ready) begin
               chk("rsp_expected", 32'(exp_q.size() != 0), 32'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("rsp_err", 32'(rsp_err), 32'(e.err));
                  if (e.chk_data) begin
                     chk("rsp_hi", 32'(rsp_hi), 32'(e.hi));
                     chk("rsp_lo", 32'(rsp_lo), 32'(e.lo));
                  end
               end
               rsp_seen++;
               held = 1'b0;
            end else begin
               held  = 1'b1;
               h_hi  = rsp_hi;
               h_lo  = rsp_lo;
               h_err = rsp_err;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] xh, input int mode);
      rsp_t        e;
      logic [15:0] r;
      r          = alu_ref(op, x, y, xh);
      e.hi       = (mode == ModeNormal) ? r[15:8] : 8'h00;
      e.lo       = (mode == ModeNormal) ? r[7:0] : 8'h00;
      e.err      = (mode != ModeNormal);
      e.chk_data = (mode != ModeEarly);
      exp_q.push_back(e);
   endtask

   // Present a request until accepted; returns the acceptance cycle, leaves time at T+1
   task automatic send(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] xh, input int mode, input int delay,
                       input bit expect_rsp, output int t);
      alu_mode  = mode;
      alu_delay = delay;
      if (expect_rsp) push_exp(op, x, y, xh, mode);
      req_op    = op;
      req_x     = x;
      req_y     = y;
      req_xh    = xh;
      req_valid = 1'b1;
      t = -1;
      for (int k = 0; k < 300; k++) begin
         if (req_ready) begin
            t = cyc;
            break;
         end
         step();
      end
      if (t < 0) chk("req_accept", 32'(req_ready), 32'(1));
      acc_cyc = t;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_valid(output int t);
      t = -1;
      for (int k = 0; k < 300; k++) begin
         if (rsp_valid) begin
            t = cyc;
            break;
         end
         step();
      end
      if (t < 0) chk("rsp_valid_seen", 32'(rsp_valid), 32'(1));
   endtask

   task automatic wait_done(input int n);
      for (int k = 0; k < 300 && rsp_seen < n; k++) step();
      chk("rsp_handshake", 32'(rsp_seen >= n), 32'(1));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin : main
      int         t, tv, n, sel, mode;
      logic [1:0] op;
      logic [7:0] x, y, xh;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_x     = 8'h00;
      req_y     = 8'h00;
      req_xh    = 8'h00;
      rsp_ready = 1'b0;
      #1 reset  = 1'b1;
      #11;
      chk("rst_req_ready", 32'(req_ready), 32'(1));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_err", 32'(rsp_err), 32'(0));
      chk("rst_rsp_data", 32'({rsp_hi, rsp_lo}), 32'(0));
      chk("rst_alu_outs", 32'({alu_begin, alu_op_code, alu_inbus}), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      step();

      // Add: word timing and END at T+6
      rsp_ready = 1'b1;
      send(2'b00, 8'h12, 8'h34, 8'h00, ModeNormal, 1, 1, t);
      chk("add_begin", 32'(alu_begin), 32'(1));
      chk("add_opcode", 32'(alu_op_code), 32'(0));
      step();
      chk("add_begin_drop", 32'(alu_begin), 32'(0));
      chk("add_word0", 32'(alu_inbus), 32'(8'h12));
      step();
      chk("add_word1", 32'(alu_inbus), 32'(8'h34));
      step();
      chk("add_no_ld2", 32'(alu_inbus), 32'(0));
      chk("add_busy", 32'(busy), 32'(1));
      wait_valid(tv);
      chk("add_rsp_cycle", 32'(tv), 32'(t + 7));
      wait_done(1);

      // Divide: three words and op_code held
      send(2'b11, 8'h00, 8'h10, 8'h01, ModeNormal, 2, 1, t);
      chk("div_opcode_start", 32'(alu_op_code), 32'(3));
      step();
      chk("div_word0", 32'(alu_inbus), 32'(8'h01));
      step();
      chk("div_word1", 32'(alu_inbus), 32'(8'h00));
      step();
      chk("div_word2", 32'(alu_inbus), 32'(8'h10));
      chk("div_opcode_ld2", 32'(alu_op_code), 32'(3));
      step();
      chk("div_opcode_wait", 32'(alu_op_code), 32'(3));
      wait_done(2);

      // Timeout after 64 WAIT_END cycles, then late END pulses ignored
      rsp_ready = 1'b0;
      send(2'b10, 8'h0f, 8'h0e, 8'h00, ModeSilent, 0, 1, t);
      wait_valid(tv);
      chk("to_rsp_cycle", 32'(tv), 32'(t + 68));
      chk("to_err", 32'(rsp_err), 32'(1));
      late_req++;
      repeat (3) step();
      chk("to_late_valid", 32'(rsp_valid), 32'(1));
      chk("to_late_ready", 32'(req_ready), 32'(0));
      rsp_ready = 1'b1;
      wait_done(3);
      chk("to_idle_busy", 32'(busy), 32'(0));
      chk("to_idle_valid", 32'(rsp_valid), 32'(0));
      chk("to_idle_err_kept", 32'(rsp_err), 32'(1));
      late_req++;
      repeat (3) step();
      chk("idle_late_busy", 32'(busy), 32'(0));
      chk("idle_late_valid", 32'(rsp_valid), 32'(0));

      // Protocol error: END during LD1 skips LD2 and WAIT_END
      send(2'b11, 8'h22, 8'h33, 8'h11, ModeEarly, 0, 1, t);
      repeat (3) step();
      chk("perr_valid", 32'(rsp_valid), 32'(1));
      chk("perr_err", 32'(rsp_err), 32'(1));
      chk("perr_no_ld2", 32'(alu_inbus), 32'(0));
      wait_done(4);

      // Backpressure: 10 stalled cycles, next request taken the cycle after handshake
      rsp_ready = 1'b0;
      send(2'b01, 8'h50, 8'h20, 8'h00, ModeNormal, 0, 1, t);
      wait_valid(tv);
      push_exp(2'b00, 8'h05, 8'h07, 8'h00, ModeNormal);
      alu_delay = 1;
      req_op    = 2'b00;
      req_x     = 8'h05;
      req_y     = 8'h07;
      req_xh    = 8'h00;
      req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_req_ready", 32'(req_ready), 32'(0));
         chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
         step();
      end
      rsp_ready = 1'b1;
      chk("bp_hs_req_ready", 32'(req_ready), 32'(0));
      step();
      chk("bp_after_valid", 32'(rsp_valid), 32'(0));
      chk("bp_after_ready", 32'(req_ready), 32'(1));
      acc_cyc = cyc;
      step();
      req_valid = 1'b0;
      wait_done(6);

      // Asynchronous reset during LD0
      send(2'b00, 8'h5a, 8'h11, 8'h00, ModeSilent, 0, 0, t);
      step();
      chk("rst_ld0_word", 32'(alu_inbus), 32'(8'h5a));
      #2 reset = 1'b1;
      #1;
      chk("arst_inbus", 32'(alu_inbus), 32'(0));
      chk("arst_begin", 32'(alu_begin), 32'(0));
      chk("arst_opcode", 32'(alu_op_code), 32'(0));
      chk("arst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("arst_rsp_lo", 32'(rsp_lo), 32'(0));
      chk("arst_busy", 32'(busy), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      step();
      chk("arst_req_ready", 32'(req_ready), 32'(1));

      // Randomised operations with random response backpressure
      n = 6;
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         x  = 8'($urandom);
         y  = 8'($urandom);
         xh = 8'($urandom);
         if (op == 2'b11) begin
            y  = 8'($urandom_range(1, 255));
            xh = 8'($urandom_range(0, int'(y) - 1));
         end
         sel  = int'($urandom_range(0, 9));
         mode = (sel == 0) ? ModeEarly : (sel == 1) ? ModeSilent : ModeNormal;
         rsp_ready = 1'b0;
         send(op, x, y, xh, mode, int'($urandom_range(0, 5)), 1, t);
         wait_valid(tv);
         repeat ($urandom_range(0, 3)) step();
         rsp_ready = 1'b1;
         n++;
         wait_done(n);
      end
      rsp_ready = 1'b0;

      chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_host_driver.md
Name: alu_host_driver

Overview:
- Host-side sequencer for the ALU operand/result bus protocol.
- Accepts an operation request on a valid/ready interface and drives the ALU's BEGIN, op_code and inbus in the required word order.
- Monitors outbus/END, captures the two result words, and returns them on a valid/ready response interface.
- Sits between the system bus and the alu instance and is the only driver of that instance's inputs.

Parameters:
- TIMEOUT_CYCLES, 64: maximum number of WAIT_END cycles before the operation is aborted with an error.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_op  in  2  00 add, 01 sub, 10 multiply (Radix-4), 11 divide (SRT-2).
- req_x  in  8  operand X; for divide, the dividend low byte.
- req_y  in  8  operand Y; for divide, the divisor.
- req_xh  in  8  dividend high byte; ignored unless req_op==11.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_hi  out  8  result word 1 (A register).
- rsp_lo  out  8  result word 2 (Q register).
- rsp_err  out  1  1 = timeout or protocol error; rsp_hi/rsp_lo are invalid.
- alu_begin  out  1  to ALU BEGIN.
- alu_op_code  out  2  to ALU op_code.
- alu_inbus  out  8  to ALU inbus.
- alu_outbus  in  8  from ALU outbus.
- alu_end  in  1  from ALU END.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous): state goes to IDLE. req_ready=1. rsp_valid=0, rsp_err=0, rsp_hi=rsp_lo=0. alu_begin=0, alu_op_code=00, alu_inbus=00. busy=0. Timeout counter and history register cleared.
- Reset asserted mid-operation: same values, effective immediately. Pending result and partial load are discarded.
- States: IDLE, START, LD0, LD1, LD2, WAIT_END, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch op, x, y, xh and go to START.
- START: alu_begin=1 for exactly one cycle; alu_op_code=latched op. Then go to LD0.
- alu_op_code is held from START until leaving WAIT_END, then returns to 00.
- LD0, LD1, LD2 (inbus only carries data in these states; 00 otherwise):
  - op 00/01/10: LD0 drives x, LD1 drives y, then WAIT_END. LD2 is skipped.
  - op 11: LD0 drives xh, LD1 drives x, LD2 drives y, then WAIT_END.
- Accept-to-last-word timing, with acceptance at cycle T:
  - BEGIN is high in T+1.
  - First word is on inbus in T+2.
  - Last word is on inbus in T+3 (2-word ops) or T+4 (divide).
- ALU result protocol: END is high for one cycle. outbus carries A in the cycle before END and Q in the END cycle.
- History register: the driver samples alu_outbus into it every cycle.
- WAIT_END:
  - The timeout counter increments each cycle.
  - On alu_end=1: rsp_hi=history (previous cycle outbus), rsp_lo=alu_outbus, rsp_err=0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without END: rsp_hi=rsp_lo=0, rsp_err=1, go to RESP.
  - END and timeout in the same cycle: END wins.
- alu_end=1 in START or LD0..LD2 is a protocol error: go to RESP with rsp_err=1, skipping the remaining loads.
- Latency: END cycle to rsp_valid=1 is 1 cycle.
- RESP:
  - rsp_valid=1. rsp_* are held stable until rsp_ready=1.
  - On rsp_ready the handshake completes and the state returns to IDLE the next cycle. rsp_valid drops in that IDLE cycle; the response outputs keep their last values.
- alu_end while in IDLE or RESP (late END after a timeout) is ignored.
- req_ready=0 in all states except IDLE; there is no request pipelining (one op in flight).
- busy = (state != IDLE).

Test Plan:
- Add: req_op=00, x=0x12, y=0x34 accepted at T. Check alu_begin=1 only at T+1, inbus=0x12 at T+2, inbus=0x34 at T+3. Model END at T+6 with outbus 0x00 then 0x46 -> rsp_valid at T+7, rsp_hi=0x00, rsp_lo=0x46, rsp_err=0.
- Divide: req_op=11, xh=0x01, x=0x00, y=0x10. Check inbus sequence 0x01, 0x00, 0x10 in T+2..T+4 and alu_op_code=11 held through WAIT_END. Model returns remainder 0x00 and quotient 0x10 -> rsp_hi=0x00, rsp_lo=0x10.
- Timeout: multiply request, model never asserts END -> rsp_valid with rsp_err=1 after exactly 64 WAIT_END cycles. A late END pulse afterwards causes no state change.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid and rsp_hi/rsp_lo are stable, req_ready=0 throughout, and a new req_valid is not accepted until the cycle after the handshake.
- Protocol error and reset:
  - END injected during LD1 -> rsp_err=1, LD2/WAIT_END skipped.
  - Separately, assert reset during LD0 -> alu_begin, alu_inbus and rsp_valid go to 0 asynchronously, req_ready=1 after release.
